logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit: one WIDTH-bit result per cycle from a 3-bit opcode (AND, OR, NAND, NOR, NOT, XOR, XNOR).
- Adds valid/ready flow control, a 2-stage pipeline, an accumulate mode that substitutes an internal result register for operand b, and per-result flags (zero, parity, popcount, illegal op).
- Sits between operand sources and any downstream consumer that can apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CW, $clog2(WIDTH+1), popcount width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  unit can accept; transfer when in_valid && in_ready.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b (ignored when in_acc=1).
- in_op  input  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 NOT(a), 5 XOR, 6 XNOR, 7 illegal.
- in_acc  input  1  use accumulator register as operand b.
- acc_clr  input  1  synchronous clear of the accumulator.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_parity  output  1  XOR-reduction of out_y.
- out_popcnt  output  CW  number of ones in out_y.
- out_err  output  1  transaction used op 7.

Behaviour:
- Reset (rst_n=0, async): s1_valid, out_valid, acc, out_y, out_zero, out_parity, out_popcnt, out_err all 0. in_ready=1 during and after reset. Reset mid-stream discards all in-flight transactions.
- Stage 1 (on accept): compute y = op(a, b_eff), with b_eff = in_acc ? acc : in_b. Register y, err (op==7) and s1_valid.
- Illegal op 7: y = 0, err = 1.
- Stage 2: register y into out_y. Compute zero, parity and popcount from stage-1 y and register them alongside, so all flags align with out_y.
- Latency: accept at cycle N -> out_valid at N+2 when there is no backpressure. Throughput: 1 transaction/cycle.
- Flow control:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational).
  - Bubbles collapse: an empty stage fills even while the downstream stage is stalled.
- While out_valid && !out_ready, all out_* hold stable. Capacity under stall is 2 transactions; in_ready drops only when both stages are full.
- Order is strictly preserved; no transaction is dropped or duplicated.
- Accumulator (WIDTH bits): loads y on every accepted transaction, regardless of in_acc.
  - acc_clr=1 clears acc to 0 next edge. Clear wins over a simultaneous load.
  - A transaction accepted in the same cycle as acc_clr still uses the pre-clear acc value as b_eff.
  - Back-to-back in_acc transactions see the previous transaction's result; there is no hazard bubble.
- in_* are sampled only on accept. Changes to in_* while in_ready=0 have no effect.
- out_valid drops the cycle after the final transfer if no new data is in stage 1.
- All arithmetic is bitwise and WIDTH-exact. Popcount max = WIDTH fits in CW. WIDTH=1 is legal.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 mid-stream with both stages full -> out_valid=0, in_ready=1, acc=0, all outputs 0 immediately; the first post-reset transaction emerges unaffected.
- Op sweep: a=0xC3, b=0x5A, ops 0..6 back-to-back, out_ready=1 -> out_y = 0x42, 0xDB, 0xBD, 0x24, 0x3C, 0x99, 0x66 on consecutive cycles starting 2 cycles after the first accept. For 0x99: popcnt=4, parity=0, zero=0.
- Illegal/zero: op=7, a=0xFF, b=0xFF -> out_y=0x00, out_err=1, out_zero=1, popcnt=0. Then op=0, a=0xF0, b=0x0F -> out_y=0x00, out_err=0, out_zero=1.
- Accumulate: pulse acc_clr, then op=OR with in_acc=1 and a = 0x01, 0x02, 0x80 -> out_y = 0x01, 0x03, 0x83. Final flags: popcnt=3, parity=1.
- Clear collision: acc=0x83, accept op=XOR, in_acc=1, a=0x0F together with acc_clr=1 -> out_y=0x8C. The next op=OR, in_acc=1, a=0x00 -> out_y=0x00.
- Backpressure: out_ready=0, offer 4 transactions continuously -> exactly 2 accepted, then in_ready=0. out_y stays stable on the first result. Release out_ready -> all 4 emerge in order with no gaps, and in_ready recovers the same cycle.

Source files
------------

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Two-stage valid/ready bitwise logic unit with accumulator and flags
//  Revision : 1.0
// ============================================================================
module logic_unit_pipe #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CW-1:0]    out_popcnt,
    output logic             out_err
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_y_q;
    logic             s1_err_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_y_q;
    logic             out_zero_q;
    logic             out_parity_q;
    logic [CW-1:0]    out_popcnt_q;
    logic             out_err_q;
    logic [WIDTH-1:0] acc_q;

    logic             s2_ready;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] y_d;
    logic             err_d;
    logic [CW-1:0]    pop_d;

    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign accept   = in_valid && in_ready;

    // acc_q here is always the pre-clear value, so a clear in the accept cycle does not affect b_eff
    assign b_eff = in_acc ? acc_q : in_b;

    always_comb begin
        y_d   = '0;
        err_d = 1'b0;
        case (in_op)
            OP_AND:  y_d = in_a & b_eff;
            OP_OR:   y_d = in_a | b_eff;
            OP_NAND: y_d = ~(in_a & b_eff);
            OP_NOR:  y_d = ~(in_a | b_eff);
            OP_NOT:  y_d = ~in_a;
            OP_XOR:  y_d = in_a ^ b_eff;
            OP_XNOR: y_d = ~(in_a ^ b_eff);
            default: err_d = 1'b1;
        endcase
    end

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_d = pop_d + CW'(s1_y_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_y_q       <= '0;
            s1_err_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_zero_q   <= 1'b0;
            out_parity_q <= 1'b0;
            out_popcnt_q <= '0;
            out_err_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_y_q     <= y_d;
                s1_err_q   <= err_d;
            end else if (s2_ready) begin
                s1_valid_q <= 1'b0;
            end

            // Flags are derived from the stage-1 result so they land in the same cycle as out_y
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_y_q      <= s1_y_q;
                    out_zero_q   <= (s1_y_q == '0);
                    out_parity_q <= ^s1_y_q;
                    out_popcnt_q <= pop_d;
                    out_err_q    <= s1_err_q;
                end
            end

            if (acc_clr) begin
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= y_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign out_popcnt = out_popcnt_q;
    assign out_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Self-checking bench: vector table, corner sequences, random vs model
//  Revision : 1.0
// ============================================================================
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_acc, acc_clr;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       out_valid, out_ready, out_zero, out_parity, out_err;
    logic [7:0] out_y;
    logic [3:0] out_popcnt;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero), .out_parity(out_parity), .out_popcnt(out_popcnt),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       acc, clr;
        logic [7:0] y;
        logic       err;
        logic [3:0] pop;
        logic       par;
    } vec_t;

    typedef struct { logic [7:0] y; logic err; } exp_t;
    typedef struct { int cyc; logic [7:0] y; logic err, zero, par; logic [3:0] pop; } obs_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    obs_t obs[$];
    int   acc_cyc[$];
    logic [7:0] m_acc = 8'h00;

    logic       stall_prev = 1'b0;
    logic [7:0] hold_y;
    logic [3:0] hold_pop;
    logic       hold_err, hold_zero, hold_par;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: everything sampled mid-cycle, where inputs and combinational ready are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc      = 8'h00;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", out_y, hold_y);
                chk("hold_flags", {out_err, out_zero, out_par_w(), out_popcnt},
                    {hold_err, hold_zero, hold_par, hold_pop});
            end
            if (out_valid && out_ready) begin
                obs.push_back('{cyc, out_y, out_err, out_zero, out_parity, out_popcnt});
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_y", out_y, e.y);
                    chk("sb_err", out_err, e.err);
                    chk("sb_zero", out_zero, (e.y == 8'h00));
                    chk("sb_parity", out_parity, ^e.y);
                    chk("sb_popcnt", out_popcnt, $countones(e.y));
                end
            end
            if (in_valid && in_ready) begin
                logic [7:0] y;
                y = ref_op(in_op, in_a, in_acc ? m_acc : in_b);
                exp_q.push_back('{y, (in_op == 3'd7)});
                acc_cyc.push_back(cyc);
                m_acc = y;
            end
            if (acc_clr) m_acc = 8'h00;
            stall_prev = out_valid && !out_ready;
            hold_y = out_y; hold_err = out_err; hold_zero = out_zero;
            hold_par = out_parity; hold_pop = out_popcnt;
        end
    end

    function automatic logic out_par_w();
        return out_parity;
    endfunction

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic clr);
        int n;
        n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; acc_clr = clr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 60) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom); in_acc = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_out_valid_low", out_valid, 0);
    endtask

    initial begin
        int   tb_base, ta_base, idx;
        logic rnd_done;

        tbl[0]  = '{3'd0, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h42, 1'b0, 4'd2, 1'b0};
        tbl[1]  = '{3'd1, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'hDB, 1'b0, 4'd6, 1'b0};
        tbl[2]  = '{3'd2, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'hBD, 1'b0, 4'd6, 1'b0};
        tbl[3]  = '{3'd3, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h24, 1'b0, 4'd2, 1'b0};
        tbl[4]  = '{3'd4, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd4, 1'b0};
        tbl[5]  = '{3'd5, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h99, 1'b0, 4'd4, 1'b0};
        tbl[6]  = '{3'd6, 8'hC3, 8'h5A, 1'b0, 1'b0, 8'h66, 1'b0, 4'd4, 1'b0};
        tbl[7]  = '{3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0};
        tbl[8]  = '{3'd0, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0};
        tbl[9]  = '{3'd1, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h01, 1'b0, 4'd1, 1'b1};
        tbl[10] = '{3'd1, 8'h02, 8'hFF, 1'b1, 1'b0, 8'h03, 1'b0, 4'd2, 1'b0};
        tbl[11] = '{3'd1, 8'h80, 8'hFF, 1'b1, 1'b0, 8'h83, 1'b0, 4'd3, 1'b1};
        tbl[12] = '{3'd5, 8'h0F, 8'hFF, 1'b1, 1'b1, 8'h8C, 1'b0, 4'd3, 1'b1};
        tbl[13] = '{3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {out_y, out_err, out_zero, out_parity, out_popcnt}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table, no backpressure
        tb_base = obs.size(); ta_base = acc_cyc.size();
        for (int i = 0; i < 14; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].clr);
        drain();
        chk("tbl_count", obs.size() - tb_base, 14);
        if (obs.size() - tb_base == 14) begin
            for (int i = 0; i < 14; i++) begin
                obs_t o;
                o = obs[tb_base + i];
                chk($sformatf("tbl%0d_y", i), o.y, tbl[i].y);
                chk($sformatf("tbl%0d_err", i), o.err, tbl[i].err);
                chk($sformatf("tbl%0d_zero", i), o.zero, (tbl[i].y == 8'h00));
                chk($sformatf("tbl%0d_par", i), o.par, tbl[i].par);
                chk($sformatf("tbl%0d_pop", i), o.pop, tbl[i].pop);
                chk($sformatf("tbl%0d_latency", i), o.cyc, acc_cyc[ta_base + i] + 2);
            end
        end

        // Backpressure: two slots, then in_ready low with out_y frozen
        out_ready = 1'b0; idx = 0;
        in_valid = 1'b1; in_op = 3'd1; in_a = 8'd1; in_b = 8'h00; in_acc = 1'b0; acc_clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 4) in_a = 8'(idx + 1); else in_valid = 1'b0;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_first_y", out_y, 8'h01);
        tb_base = obs.size();
        out_ready = 1'b1;
        #1 chk("bp_in_ready_recover", in_ready, 1);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 4) in_a = 8'(idx + 1); else in_valid = 1'b0;
        end
        drain();
        chk("bp_count", obs.size() - tb_base, 4);
        if (obs.size() - tb_base == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("bp%0d_y", k), obs[tb_base + k].y, k + 1);
                if (k > 0) chk($sformatf("bp%0d_nogap", k), obs[tb_base + k].cyc, obs[tb_base + k - 1].cyc + 1);
            end
        end

        // Reset with both stages full and a nonzero accumulator
        out_ready = 1'b0;
        send(3'd5, 8'hA5, 8'h00, 1'b0, 1'b0);
        send(3'd5, 8'h5A, 8'h00, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_outputs", {out_y, out_err, out_zero, out_parity, out_popcnt}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        tb_base = obs.size();
        send(3'd5, 8'h3C, 8'h0F, 1'b0, 1'b0);
        send(3'd1, 8'h00, 8'hFF, 1'b1, 1'b0);
        drain();
        chk("postrst_count", obs.size() - tb_base, 2);
        if (obs.size() - tb_base == 2) begin
            chk("postrst_first_y", obs[tb_base].y, 8'h33);
            chk("postrst_acc_y", obs[tb_base + 1].y, 8'h33);
        end

        // Random traffic with random backpressure, checked by the scoreboard
        rnd_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    send(3'($urandom), 8'($urandom), 8'($urandom),
                         ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
